alu_issue_stage: RTL and testbench

- Issue stage directly upstream of the 16-bit ALU.
- Accepts decoded-field instruction packets over a valid/ready handshake and translates opcode/funct into the 4-bit ALUop.
- Selects and extends the second operand, and buffers packets in a 2-entry FIFO.
- Presents registered Data_in1/Data_in2/ALUop to the ALU with a valid/ready handshake toward the consumer (EX/WB latch).

---
 rtl/alu_issue_stage.sv | 227 ++++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_stage
//  Purpose  : Issue stage in front of the 16-bit ALU. Decodes opcode/funct
//             into an ALUop, selects/extends operand 2, buffers packets in a
//             2-entry FIFO and presents registered operands to the consumer.
//  Revision : 1.0  initial release
// ============================================================================
module alu_issue_stage #(
    parameter int INTERNAL_BITS = 16,
    parameter int ALUOP_BITS    = 4,
    parameter int IMM_BITS      = 8,
    parameter int DEPTH         = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    // upstream handshake and decoded fields
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [5:0]               opcode,
    input  logic [5:0]               funct,
    input  logic [INTERNAL_BITS-1:0] rs_val,
    input  logic [INTERNAL_BITS-1:0] rt_val,
    input  logic [IMM_BITS-1:0]      imm,
    // downstream handshake toward the EX/WB latch
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INTERNAL_BITS-1:0] Data_in1,
    output logic [INTERNAL_BITS-1:0] Data_in2,
    output logic [ALUOP_BITS-1:0]    ALUop,
    // sticky error flag for dropped, undecodable packets
    output logic                     illegal,
    input  logic                     illegal_clr
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [ALUOP_BITS-1:0] c_aluop_and = ALUOP_BITS'(4'b0000);
    localparam logic [ALUOP_BITS-1:0] c_aluop_or  = ALUOP_BITS'(4'b0001);
    localparam logic [ALUOP_BITS-1:0] c_aluop_add = ALUOP_BITS'(4'b0010);
    localparam logic [ALUOP_BITS-1:0] c_aluop_sub = ALUOP_BITS'(4'b0110);
    localparam logic [ALUOP_BITS-1:0] c_aluop_slt = ALUOP_BITS'(4'b0111);
    localparam logic [ALUOP_BITS-1:0] c_aluop_nor = ALUOP_BITS'(4'b1100);

    localparam logic [5:0] c_opc_rtype = 6'h00;
    localparam logic [5:0] c_opc_beq   = 6'h04;
    localparam logic [5:0] c_opc_addi  = 6'h08;
    localparam logic [5:0] c_opc_slti  = 6'h0A;
    localparam logic [5:0] c_opc_andi  = 6'h0C;
    localparam logic [5:0] c_opc_ori   = 6'h0D;

    localparam logic [5:0] c_fn_add = 6'h20;
    localparam logic [5:0] c_fn_sub = 6'h22;
    localparam logic [5:0] c_fn_and = 6'h24;
    localparam logic [5:0] c_fn_or  = 6'h25;
    localparam logic [5:0] c_fn_nor = 6'h27;
    localparam logic [5:0] c_fn_slt = 6'h2A;

    // One FIFO entry is {operand1, operand2, aluop}
    localparam int          c_entry_w = 2 * INTERNAL_BITS + ALUOP_BITS;
    localparam logic [1:0]  c_depth   = 2'(DEPTH);

    // ------------------------------------------------------------------
    // Immediate extension (sign and zero)
    // ------------------------------------------------------------------
    logic [INTERNAL_BITS-1:0] w_imm_sext;
    logic [INTERNAL_BITS-1:0] w_imm_zext;

    generate
        if (INTERNAL_BITS > IMM_BITS) begin : g_ext_pad
            assign w_imm_sext = {{(INTERNAL_BITS-IMM_BITS){imm[IMM_BITS-1]}}, imm};
            assign w_imm_zext = {{(INTERNAL_BITS-IMM_BITS){1'b0}}, imm};
        end else begin : g_ext_none
            // Immediate already spans the full datapath width
            assign w_imm_sext = imm;
            assign w_imm_zext = imm;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic                     w_legal;
    logic [ALUOP_BITS-1:0]    w_aluop;
    logic [INTERNAL_BITS-1:0] w_op2;

    // Translate opcode/funct into ALUop and pick operand 2
    always_comb begin
        w_legal = 1'b0;
        w_aluop = c_aluop_and;
        w_op2   = rt_val;
        case (opcode)
            c_opc_rtype: begin
                w_op2   = rt_val;
                w_legal = 1'b1;
                case (funct)
                    c_fn_and: w_aluop = c_aluop_and;
                    c_fn_or:  w_aluop = c_aluop_or;
                    c_fn_add: w_aluop = c_aluop_add;
                    c_fn_sub: w_aluop = c_aluop_sub;
                    c_fn_slt: w_aluop = c_aluop_slt;
                    c_fn_nor: w_aluop = c_aluop_nor;
                    default:  w_legal = 1'b0;
                endcase
            end
            c_opc_addi: begin
                w_legal = 1'b1;
                w_aluop = c_aluop_add;
                w_op2   = w_imm_sext;
            end
            c_opc_slti: begin
                w_legal = 1'b1;
                w_aluop = c_aluop_slt;
                w_op2   = w_imm_sext;
            end
            c_opc_andi: begin
                w_legal = 1'b1;
                w_aluop = c_aluop_and;
                w_op2   = w_imm_zext;
            end
            c_opc_ori: begin
                w_legal = 1'b1;
                w_aluop = c_aluop_or;
                w_op2   = w_imm_zext;
            end
            c_opc_beq: begin
                w_legal = 1'b1;
                w_aluop = c_aluop_sub;
                w_op2   = rt_val;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [DEPTH-1:0][c_entry_w-1:0] mem_q, mem_d;
    logic                            wr_ptr_q, wr_ptr_d;
    logic                            rd_ptr_q, rd_ptr_d;
    logic [1:0]                      count_q, count_d;
    logic [c_entry_w-1:0]            head_q, head_d;
    logic                            illegal_q, illegal_d;

    logic w_accept;
    logic w_push;
    logic w_pop;

    // Ready depends only on stored occupancy, never on out_ready
    assign in_ready  = (count_q < c_depth);
    assign out_valid = (count_q != 2'd0);

    assign w_accept = in_valid && in_ready;
    assign w_push   = w_accept && w_legal;
    assign w_pop    = out_valid && out_ready;

    // Next-state for storage, pointers, occupancy and the output head register
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;

        if (w_push) begin
            mem_d[wr_ptr_q] = {rs_val, w_op2, w_aluop};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (w_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // Head register mirrors the entry that will be at the front after this
        // edge; when the FIFO drains it keeps the last popped packet.
        if (count_d != 2'd0) begin
            head_d = mem_d[rd_ptr_d];
        end
    end

    // Sticky illegal flag: a new illegal accept wins over a clear
    always_comb begin
        illegal_d = illegal_q;
        if (w_accept && !w_legal) begin
            illegal_d = 1'b1;
        end else if (illegal_clr) begin
            illegal_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q     <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            head_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            head_q    <= head_d;
            illegal_q <= illegal_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign Data_in1 = head_q[c_entry_w-1 -: INTERNAL_BITS];
    assign Data_in2 = head_q[ALUOP_BITS +: INTERNAL_BITS];
    assign ALUop    = head_q[ALUOP_BITS-1:0];
    assign illegal  = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue_stage
//  Purpose  : Self-checking bench for alu_issue_stage using a queue-based
//             reference model and randomized packets.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] rs_val;
    logic [15:0] rt_val;
    logic [7:0]  imm;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Data_in1;
    logic [15:0] Data_in2;
    logic [3:0]  ALUop;
    logic        illegal;
    logic        illegal_clr;

    alu_issue_stage #(
        .INTERNAL_BITS(16),
        .ALUOP_BITS   (4),
        .IMM_BITS     (8),
        .DEPTH        (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .funct      (funct),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .imm        (imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Data_in1   (Data_in1),
        .Data_in2   (Data_in2),
        .ALUop      (ALUop),
        .illegal    (illegal),
        .illegal_clr(illegal_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
    } pkt_t;

    typedef struct packed {
        logic legal;
        pkt_t p;
    } dec_t;

    // Reference model state
    pkt_t mq[$];
    pkt_t m_last;
    bit   m_illegal;

    int n_cmp;
    int n_bad;

    // Instruction-set table: what the ALU must be asked to do
    function automatic dec_t ref_decode(logic [5:0] opc, logic [5:0] fn,
                                        logic [15:0] rs, logic [15:0] rt,
                                        logic [7:0] im);
        dec_t d;
        d.legal = 1'b1;
        d.p.a   = rs;
        d.p.b   = rt;
        d.p.op  = 4'b0000;
        if (opc == 6'h00) begin
            if      (fn == 6'h24) d.p.op = 4'b0000;
            else if (fn == 6'h25) d.p.op = 4'b0001;
            else if (fn == 6'h20) d.p.op = 4'b0010;
            else if (fn == 6'h22) d.p.op = 4'b0110;
            else if (fn == 6'h2A) d.p.op = 4'b0111;
            else if (fn == 6'h27) d.p.op = 4'b1100;
            else d.legal = 1'b0;
        end else if (opc == 6'h08) begin
            d.p.op = 4'b0010;
            d.p.b  = 16'($signed(im));
        end else if (opc == 6'h0A) begin
            d.p.op = 4'b0111;
            d.p.b  = 16'($signed(im));
        end else if (opc == 6'h0C) begin
            d.p.op = 4'b0000;
            d.p.b  = {8'h00, im};
        end else if (opc == 6'h0D) begin
            d.p.op = 4'b0001;
            d.p.b  = {8'h00, im};
        end else if (opc == 6'h04) begin
            d.p.op = 4'b0110;
        end else begin
            d.legal = 1'b0;
        end
        return d;
    endfunction

    // Observable bundle: {in_ready, out_valid, illegal, Data_in1, Data_in2, ALUop}
    function automatic logic [38:0] dut_obs();
        return {in_ready, out_valid, illegal, Data_in1, Data_in2, ALUop};
    endfunction

    function automatic logic [38:0] model_obs();
        pkt_t h;
        h = (mq.size() > 0) ? mq[0] : m_last;
        return {(mq.size() < 2), (mq.size() > 0), m_illegal, h.a, h.b, h.op};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_last    = '0;
        m_illegal = 1'b0;
    endtask

    task automatic drive(bit v, logic [5:0] opc, logic [5:0] fn,
                         logic [15:0] rs, logic [15:0] rt, logic [7:0] im);
        in_valid = v;
        opcode   = opc;
        funct    = fn;
        rs_val   = rs;
        rt_val   = rt;
        imm      = im;
    endtask

    // Random packet; illegal forms only when allowed
    task automatic drive_rand(bit allow_illegal);
        int k;
        logic [5:0] opc;
        logic [5:0] fn;
        k   = allow_illegal ? $urandom_range(0, 12) : $urandom_range(0, 10);
        fn  = 6'($urandom);
        opc = 6'h00;
        case (k)
            0:  fn = 6'h24;
            1:  fn = 6'h25;
            2:  fn = 6'h20;
            3:  fn = 6'h22;
            4:  fn = 6'h2A;
            5:  fn = 6'h27;
            6:  opc = 6'h08;
            7:  opc = 6'h0A;
            8:  opc = 6'h0C;
            9:  opc = 6'h0D;
            10: opc = 6'h04;
            11: opc = 6'h3F;
            default: fn = 6'h01;
        endcase
        drive(1'b1, opc, fn, 16'($urandom), 16'($urandom), 8'($urandom));
    endtask

    // Advance one clock (called at a negedge) and step the reference model
    task automatic tick();
        dec_t d;
        bit   acc;
        bit   pop;
        d   = ref_decode(opcode, funct, rs_val, rt_val, imm);
        acc = in_valid && (mq.size() < 2);
        pop = (mq.size() > 0) && out_ready;
        @(posedge clk);
        if (pop) m_last = mq.pop_front();
        if (acc && d.legal) mq.push_back(d.p);
        if (acc && !d.legal) m_illegal = 1'b1;
        else if (illegal_clr) m_illegal = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        out_ready   = 1'b0;
        illegal_clr = 1'b0;
        drive(1'b0, 6'h00, 6'h00, 16'h0, 16'h0, 8'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        n_cmp++;
        if (dut_obs() !== {1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0}) begin
            n_bad++;
            $display("FAIL reset_state: got %h expected %h", dut_obs(),
                     {1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0});
        end
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        drive(1'b1, 6'h00, 6'h20, 16'h0003, 16'h0004, 8'h00);
        tick();
        n_cmp++;
        if ({out_valid, Data_in1, Data_in2, ALUop} !== {1'b1, 16'h0003, 16'h0004, 4'b0010}) begin
            n_bad++;
            $display("FAIL add_out: got %h expected %h", {out_valid, Data_in1, Data_in2, ALUop},
                     {1'b1, 16'h0003, 16'h0004, 4'b0010});
        end
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (dut_obs() !== model_obs() || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL add_drain: got %h expected %h", dut_obs(), model_obs());
        end
    endtask

    task automatic test_imm_ext();
        out_ready = 1'b1;
        drive(1'b1, 6'h08, 6'h15, 16'h0010, 16'hABCD, 8'hFF);
        tick();
        n_cmp++;
        if ({out_valid, Data_in1, Data_in2, ALUop} !== {1'b1, 16'h0010, 16'hFFFF, 4'b0010}) begin
            n_bad++;
            $display("FAIL addi_sext: got %h expected %h", {out_valid, Data_in1, Data_in2, ALUop},
                     {1'b1, 16'h0010, 16'hFFFF, 4'b0010});
        end
        in_valid = 1'b0;
        tick();
        drive(1'b1, 6'h0C, 6'h15, 16'h0010, 16'hABCD, 8'hFF);
        tick();
        n_cmp++;
        if ({out_valid, Data_in2, ALUop} !== {1'b1, 16'h00FF, 4'b0000}) begin
            n_bad++;
            $display("FAIL andi_zext: got %h expected %h", {out_valid, Data_in2, ALUop},
                     {1'b1, 16'h00FF, 4'b0000});
        end
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (dut_obs() !== model_obs()) begin
            n_bad++;
            $display("FAIL imm_drain: got %h expected %h", dut_obs(), model_obs());
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] seen[$];
        bit          was_ready;
        out_ready = 1'b0;
        drive(1'b1, 6'h00, 6'h25, 16'h1111, 16'h0001, 8'h00);
        tick();
        drive(1'b1, 6'h00, 6'h22, 16'h2222, 16'h0002, 8'h00);
        tick();
        n_cmp++;
        if (in_ready !== 1'b0 || Data_in1 !== 16'h1111 || dut_obs() !== model_obs()) begin
            n_bad++;
            $display("FAIL full_after_two: got %h expected %h", dut_obs(), model_obs());
        end
        drive(1'b1, 6'h0D, 6'h00, 16'h3333, 16'h0003, 8'h5A);
        tick();
        tick();
        n_cmp++;
        if (in_ready !== 1'b0 || Data_in1 !== 16'h1111 || dut_obs() !== model_obs()) begin
            n_bad++;
            $display("FAIL hold_while_stalled: got %h expected %h", dut_obs(), model_obs());
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (dut_obs() !== model_obs()) begin
                n_bad++;
                $display("FAIL drain_cycle%0d: got %h expected %h", i, dut_obs(), model_obs());
            end
            if (out_valid) seen.push_back(Data_in1);
            was_ready = in_ready;
            tick();
            if (in_valid && was_ready) in_valid = 1'b0;
        end
        n_cmp++;
        if (seen.size() != 3 || seen[0] !== 16'h1111 || seen[1] !== 16'h2222 ||
            seen[2] !== 16'h3333) begin
            n_bad++;
            $display("FAIL order: got %0d packets first %h expected 3 packets 1111,2222,3333",
                     seen.size(), (seen.size() > 0) ? seen[0] : 16'hxxxx);
        end
    endtask

    task automatic test_illegal();
        logic [15:0] seen[$];
        out_ready = 1'b1;
        drive(1'b1, 6'h00, 6'h20, 16'hAAAA, 16'h0001, 8'h00);
        tick();
        if (out_valid) seen.push_back(Data_in1);
        drive(1'b1, 6'h3F, 6'h20, 16'hDEAD, 16'h0002, 8'h00);
        tick();
        if (out_valid) seen.push_back(Data_in1);
        drive(1'b1, 6'h04, 6'h00, 16'hBBBB, 16'h0003, 8'h00);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (out_valid) seen.push_back(Data_in1);
            tick();
        end
        n_cmp++;
        if (illegal !== 1'b1 || seen.size() != 2 || seen[0] !== 16'hAAAA || seen[1] !== 16'hBBBB) begin
            n_bad++;
            $display("FAIL illegal_drop: illegal %b, %0d packets seen expected illegal 1, 2 packets AAAA,BBBB",
                     illegal, seen.size());
        end
        illegal_clr = 1'b1;
        tick();
        illegal_clr = 1'b0;
        n_cmp++;
        if (illegal !== 1'b0 || dut_obs() !== model_obs()) begin
            n_bad++;
            $display("FAIL illegal_clr: got %h expected %h", dut_obs(), model_obs());
        end
        drive(1'b1, 6'h00, 6'h3B, 16'h1234, 16'h0000, 8'h00);
        tick();
        illegal_clr = 1'b1;
        drive(1'b1, 6'h3F, 6'h00, 16'h5678, 16'h0000, 8'h00);
        tick();
        illegal_clr = 1'b0;
        in_valid    = 1'b0;
        n_cmp++;
        if (illegal !== 1'b1 || dut_obs() !== model_obs()) begin
            n_bad++;
            $display("FAIL set_beats_clr: got %h expected %h", dut_obs(), model_obs());
        end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        drive_rand(1'b0);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive_rand(1'b0);
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || dut_obs() !== model_obs()) begin
                n_bad++;
                $display("FAIL stream_cycle%0d: got %h expected %h", i, dut_obs(), model_obs());
            end
            tick();
        end
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || dut_obs() !== model_obs()) begin
            n_bad++;
            $display("FAIL stream_drain: got %h expected %h", dut_obs(), model_obs());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 7) drive_rand(1'b1);
            else in_valid = 1'b0;
            out_ready   = ($urandom_range(0, 9) < 6);
            illegal_clr = ($urandom_range(0, 7) == 0);
            n_cmp++;
            if (dut_obs() !== model_obs()) begin
                n_bad++;
                $display("FAIL random_cycle%0d: got %h expected %h", i, dut_obs(), model_obs());
            end
            tick();
        end
        illegal_clr = 1'b0;
        in_valid    = 1'b0;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(1'b1, 6'h0D, 6'h00, 16'h7777, 16'h0000, 8'h12);
        tick();
        drive(1'b1, 6'h08, 6'h00, 16'h8888, 16'h0000, 8'h80);
        tick();
        drive(1'b1, 6'h3F, 6'h00, 16'h9999, 16'h0000, 8'h00);
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || dut_obs() !== model_obs()) begin
            n_bad++;
            $display("FAIL full_before_reset: got %h expected %h", dut_obs(), model_obs());
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dut_obs() !== {1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0}) begin
            n_bad++;
            $display("FAIL async_reset: got %h expected %h", dut_obs(),
                     {1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0});
        end
        model_reset();
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b0 || dut_obs() !== model_obs()) begin
                n_bad++;
                $display("FAIL no_stale_%0d: got %h expected %h", i, dut_obs(), model_obs());
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_add();
        test_imm_ext();
        test_back_to_back();
        test_illegal();
        test_streaming();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Guard against a run that never completes
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
